// File: rtl/grf_mp.sv
// Multi-ported register file with two write ports, NRD combinational read ports,
// optional same-cycle write forwarding and a per-register pending (scoreboard) bit.
module grf_mp #(
    parameter int WIDTH    = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                 Clk_i,
    input  logic                 Reset_i,
    input  logic [NRD*AW-1:0]    RS_i,
    output logic [NRD*WIDTH-1:0] RData_o,
    output logic [NRD-1:0]       RBusy_o,
    input  logic                 WE0_i,
    input  logic                 WE1_i,
    input  logic [AW-1:0]        WA0_i,
    input  logic [AW-1:0]        WA1_i,
    input  logic [WIDTH-1:0]     WD0_i,
    input  logic [WIDTH-1:0]     WD1_i,
    input  logic                 WClr0_i,
    input  logic                 WClr1_i,
    input  logic                 IssueEn_i,
    input  logic [AW-1:0]        IssueRD_i,
    output logic [AW:0]          BusyCount_o
);

    localparam int DEPTH = 1 << AW;
    localparam bit ZR    = (ZERO_REG != 0);
    localparam bit BYP   = (BYPASS != 0);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]            pend_q, pend_d;
    logic [AW:0]                 cnt_q, cnt_d;

    logic wr0_ok, wr1_ok, clr0, clr1, set_ok;

    assign wr0_ok = WE0_i && !(ZR && (WA0_i == '0));
    assign wr1_ok = WE1_i && !(ZR && (WA1_i == '0));
    assign clr0   = WE0_i && WClr0_i;
    assign clr1   = WE1_i && WClr1_i;
    assign set_ok = IssueEn_i && !(ZR && (IssueRD_i == '0));

    // Port 1 is applied last so it wins an address collision.
    always_comb begin
        mem_d = mem_q;
        if (wr0_ok) mem_d[WA0_i] = WD0_i;
        if (wr1_ok) mem_d[WA1_i] = WD1_i;
    end

    // Set is applied after clears: a new producer supersedes the retiring one.
    always_comb begin
        pend_d = pend_q;
        if (clr0)   pend_d[WA0_i]     = 1'b0;
        if (clr1)   pend_d[WA1_i]     = 1'b0;
        if (set_ok) pend_d[IssueRD_i] = 1'b1;
    end

    // Counting the next-state bits keeps BusyCount aligned with the pending bits.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + (AW+1)'(pend_d[i]);
        end
    end

    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            mem_q  <= '0;
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign BusyCount_o = cnt_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] rd;
        logic             busy;

        assign ra = RS_i[k*AW +: AW];

        always_comb begin
            rd   = mem_q[ra];
            busy = pend_q[ra];
            if (BYP) begin
                if (WE0_i && (WA0_i == ra)) rd = WD0_i;
                if (WE1_i && (WA1_i == ra)) rd = WD1_i;
                if ((clr0 && (WA0_i == ra)) || (clr1 && (WA1_i == ra))) busy = 1'b0;
            end
            if (ZR && (ra == '0)) rd = '0;
            // Outputs are forced quiet while reset is held, independent of the clock.
            if (!Reset_i) begin
                rd   = '0;
                busy = 1'b0;
            end
        end

        assign RData_o[k*WIDTH +: WIDTH] = rd;
        assign RBusy_o[k]                = busy;
    end

endmodule

// File: tb/tb_grf_mp.sv
// Randomized + directed bench for grf_mp: one forwarding and one non-forwarding
// instance share stimulus and are checked against an array/queue-level model.
module tb_grf_mp;
    localparam int W   = 32;
    localparam int AW  = 5;
    localparam int NRD = 2;
    localparam int D   = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NRD*AW-1:0] rs;
    logic [NRD*W-1:0]  rd1, rd0;
    logic [NRD-1:0]    rb1, rb0;
    logic [AW:0]       cnt1, cnt0;
    logic              we0, we1, wc0, wc1, iss;
    logic [AW-1:0]     wa0, wa1, ird;
    logic [W-1:0]      wd0, wd1;

    int ncmp = 0;
    int nerr = 0;

    logic [W-1:0] m_mem [D];
    bit           m_pend [D];

    grf_mp #(.WIDTH(W), .AW(AW), .NRD(NRD), .BYPASS(1), .ZERO_REG(1)) dut (
        .Clk_i(clk), .Reset_i(rst_n), .RS_i(rs), .RData_o(rd1), .RBusy_o(rb1),
        .WE0_i(we0), .WE1_i(we1), .WA0_i(wa0), .WA1_i(wa1), .WD0_i(wd0), .WD1_i(wd1),
        .WClr0_i(wc0), .WClr1_i(wc1), .IssueEn_i(iss), .IssueRD_i(ird), .BusyCount_o(cnt1));

    grf_mp #(.WIDTH(W), .AW(AW), .NRD(NRD), .BYPASS(0), .ZERO_REG(1)) dut0 (
        .Clk_i(clk), .Reset_i(rst_n), .RS_i(rs), .RData_o(rd0), .RBusy_o(rb0),
        .WE0_i(we0), .WE1_i(we1), .WA0_i(wa0), .WA1_i(wa1), .WD0_i(wd0), .WD1_i(wd1),
        .WClr0_i(wc0), .WClr1_i(wc1), .IssueEn_i(iss), .IssueRD_i(ird), .BusyCount_o(cnt0));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] e_rd(input logic [AW-1:0] a, input bit byp);
        if (!rst_n || a == 0) return '0;
        if (byp && we1 && wa1 == a) return wd1;
        if (byp && we0 && wa0 == a) return wd0;
        return m_mem[a];
    endfunction

    function automatic bit e_busy(input logic [AW-1:0] a, input bit byp);
        if (!rst_n) return 1'b0;
        if (byp && ((we0 && wc0 && wa0 == a) || (we1 && wc1 && wa1 == a))) return 1'b0;
        return m_pend[a];
    endfunction

    function automatic int e_cnt();
        int n = 0;
        if (!rst_n) return 0;
        foreach (m_pend[i]) n += int'(m_pend[i]);
        return n;
    endfunction

    task automatic model_clear();
        foreach (m_mem[i]) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_clear();
        end else begin
            if (we0 && wa0 != 0) m_mem[wa0] = wd0;
            if (we1 && wa1 != 0) m_mem[wa1] = wd1;
            if (we0 && wc0) m_pend[wa0] = 1'b0;
            if (we1 && wc1) m_pend[wa1] = 1'b0;
            if (iss && ird != 0) m_pend[ird] = 1'b1;
        end
    endtask

    task automatic compare_all();
        logic [AW-1:0] a;
        for (int k = 0; k < NRD; k++) begin
            a = rs[k*AW +: AW];
            chk($sformatf("rdata%0d_byp a=%0d", k, a), rd1[k*W +: W], e_rd(a, 1'b1));
            chk($sformatf("rdata%0d_nobyp a=%0d", k, a), rd0[k*W +: W], e_rd(a, 1'b0));
            chk($sformatf("rbusy%0d_byp a=%0d", k, a), rb1[k], e_busy(a, 1'b1));
            chk($sformatf("rbusy%0d_nobyp a=%0d", k, a), rb0[k], e_busy(a, 1'b0));
        end
        chk("busycount_byp", cnt1, e_cnt());
        chk("busycount_nobyp", cnt0, e_cnt());
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; wc0 = 0; wc1 = 0; iss = 0;
        wa0 = '0; wa1 = '0; ird = '0; wd0 = '0; wd1 = '0;
    endtask

    function automatic logic [AW-1:0] raddr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom);
        return AW'($urandom_range(0, 7));
    endfunction

    initial begin
        rst_n = 1'b0;
        rs = '0;
        idle();
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Post-reset scan of every address.
        for (int a = 0; a < D; a += 2) begin
            rs = {AW'(a + 1), AW'(a)};
            #1;
            chk("scan rdata", rd1, '0);
            chk("scan rbusy", rb1, '0);
            chk("scan count", cnt1, '0);
            step();
        end

        // Forwarding vs. stored-only read of a same-cycle write.
        rs = {AW'(0), AW'(5)};
        we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF;
        #1;
        chk("bypass same cycle", rd1[W-1:0], 32'hDEADBEEF);
        chk("nobypass same cycle", rd0[W-1:0], 32'h0);
        step();
        idle();
        #1;
        chk("nobypass next cycle", rd0[W-1:0], 32'hDEADBEEF);

        // Write collision and zero register.
        we0 = 1; wa0 = 7; wd0 = 32'h11111111;
        we1 = 1; wa1 = 7; wd1 = 32'h22222222;
        step();
        idle();
        rs = {AW'(0), AW'(7)};
        #1;
        chk("collision byp", rd1[W-1:0], 32'h22222222);
        chk("collision nobyp", rd0[W-1:0], 32'h22222222);
        we0 = 1; wa0 = 0; wd0 = 32'hFFFFFFFF;
        #1;
        chk("zero reg bypass", rd1[2*W-1:W], 32'h0);
        step();
        idle();
        #1;
        chk("zero reg stored", rd0[2*W-1:W], 32'h0);

        // Issue reg 3, retire it with a clearing write two cycles later.
        rs = {AW'(0), AW'(3)};
        iss = 1; ird = 3;
        #1;
        chk("issue c0 busy", rb1[0], 1'b0);
        chk("issue c0 count", cnt1, 6'd0);
        step();
        idle();
        #1;
        chk("issue c1 busy", rb1[0], 1'b1);
        chk("issue c1 count", cnt1, 6'd1);
        step();
        we1 = 1; wa1 = 3; wc1 = 1; wd1 = 32'h33;
        #1;
        chk("clear c2 busy byp", rb1[0], 1'b0);
        chk("clear c2 busy nobyp", rb0[0], 1'b1);
        chk("clear c2 count", cnt1, 6'd1);
        step();
        idle();
        #1;
        chk("clear c3 busy", rb0[0], 1'b0);
        chk("clear c3 count", cnt1, 6'd0);

        // Set and clear of reg 9 in the same cycle: set wins.
        rs = {AW'(0), AW'(9)};
        iss = 1; ird = 9;
        step();
        we0 = 1; wa0 = 9; wc0 = 1; wd0 = 32'h99;
        step();
        idle();
        #1;
        chk("set wins busy", rb0[0], 1'b1);
        chk("set wins count", cnt1, 6'd1);

        // Regs 1-4 pending with data, then async reset between edges.
        iss = 1; ird = 1; we0 = 1; wa0 = 1; wd0 = 32'hA1; we1 = 1; wa1 = 2; wd1 = 32'hB2;
        step();
        idle(); iss = 1; ird = 2;
        step();
        idle(); iss = 1; ird = 3; we0 = 1; wa0 = 3; wd0 = 32'hC3;
        step();
        idle(); iss = 1; ird = 4; we0 = 1; wa0 = 4; wd0 = 32'hD4;
        step();
        idle();
        rs = {AW'(2), AW'(1)};
        #1;
        chk("pre-reset count", cnt1, 6'd5);
        chk("pre-reset data", rd1[W-1:0], 32'hA1);
        rst_n = 1'b0;
        #1;
        chk("async rdata", rd1, '0);
        chk("async rbusy", rb1, '0);
        chk("async count", cnt1, '0);
        we0 = 1; wa0 = 6; wd0 = 32'h66; iss = 1; ird = 6;
        step();
        rst_n = 1'b1;
        idle();
        rs = {AW'(6), AW'(1)};
        #1;
        chk("after reset reg1", rd1[W-1:0], 32'h0);
        chk("dropped write reg6", rd1[2*W-1:W], 32'h0);
        chk("dropped issue reg6", rb1[1], 1'b0);
        step();

        // Random traffic with occasional reset pulses.
        for (int i = 0; i < 800; i++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            we0 = 1'($urandom); we1 = 1'($urandom);
            wc0 = 1'($urandom); wc1 = 1'($urandom);
            iss = 1'($urandom);
            wa0 = raddr(); wa1 = raddr(); ird = raddr();
            wd0 = $urandom; wd1 = $urandom;
            rs = {raddr(), raddr()};
            step();
        end
        rst_n = 1'b1;
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/grf_mp.md
GRF_MP -- requirements
Module: grf_mp

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width of each register.
REQ-002 SHALL have parameter AW, default 5: address width; depth is 2**AW registers.
REQ-003 SHALL have parameter NRD, default 2: number of read ports, minimum 1.
REQ-004 SHALL have parameter BYPASS, default 1: 1 = a same-cycle write is forwarded to reads; 0 = reads return stored contents only.
REQ-005 SHALL have parameter ZERO_REG, default 1: 1 = register 0 reads 0, ignores writes and is never busy.
REQ-006 Clk  input  1  clock; all state updates on its rising edge.
REQ-007 Reset  input  1  asynchronous, active-low reset.
REQ-008 RS  input  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW].
REQ-009 RData  output  NRD*WIDTH  packed read data; port k uses bits [k*WIDTH +: WIDTH].
REQ-010 RBusy  output  NRD  per-port flag: the addressed register has a pending producer.
REQ-011 WE0, WE1  input  1 each  write enables for write ports 0 and 1.
REQ-012 WA0, WA1  input  AW each  write addresses.
REQ-013 WD0, WD1  input  WIDTH each  write data.
REQ-014 WClr0, WClr1  input  1 each  when the matching WE is high, the write also retires the pending flag of WA.
REQ-015 IssueEn  input  1  marks register IssueRD pending.
REQ-016 IssueRD  input  AW  register to mark pending.
REQ-017 BusyCount  output  AW+1  number of registers currently pending.

Function
REQ-018 Register array SHALL update only on the rising Clk edge while Reset is high.
REQ-019 Write ports SHALL update the array on the edge where WE is high; with ZERO_REG=1 and address 0, the write SHALL have no effect.
REQ-020 If both write ports hit the same address in one cycle, port 1 data SHALL be stored.
REQ-021 Reads SHALL be combinational with zero latency.
REQ-022 With BYPASS=1, when a read address matches an enabled write address in the same cycle, RData SHALL return that write data; port 1 SHALL take priority over port 0.
REQ-023 With BYPASS=0, RData SHALL return the contents stored before the edge.
REQ-024 With ZERO_REG=1, a read of address 0 SHALL return 0 regardless of bypass.
REQ-025 Each register SHALL have one pending bit.
REQ-026 A pending bit SHALL be set on the edge where IssueEn is high, except address 0 when ZERO_REG=1.
REQ-027 A pending bit SHALL be cleared on the edge where WE and WClr are high for that address.
REQ-028 If set and clear hit the same register in one cycle, set SHALL win, because the new producer supersedes the old one.
REQ-029 RBusy[k] SHALL be combinational from the registered pending bits; with BYPASS=1 it SHALL read 0 when an enabled clearing write to that address occurs in the same cycle.
REQ-030 BusyCount SHALL equal the population count of the pending bits and SHALL be registered, updating one cycle after a change.
REQ-031 Write ports without WClr SHALL NOT alter pending bits.

Reset
REQ-032 Reset low SHALL asynchronously clear all registers, pending bits and BusyCount to 0.
REQ-033 While Reset is low, RData SHALL be 0, RBusy SHALL be 0 and all write and issue inputs SHALL be ignored.
REQ-034 Asserting Reset mid-operation SHALL discard any write or issue in flight; the first edge after deassertion SHALL operate normally.

Verification
REQ-035 Reset low, then high; read all addresses -> every RData = 0, RBusy = 0, BusyCount = 0.
REQ-036 Write reg 5 = 0xDEADBEEF on WE0 while RS port 0 = 5, BYPASS=1 -> RData port 0 = 0xDEADBEEF in the same cycle; BYPASS=0 -> old value in that cycle, new value next cycle.
REQ-037 WE0 and WE1 both to reg 7 with 0x11111111 and 0x22222222 -> stored value 0x22222222; write 0xFFFFFFFF to reg 0 with ZERO_REG=1 -> reg 0 reads 0.
REQ-038 IssueEn to reg 3, then WE1 with WClr1 to reg 3 two cycles later -> RBusy high for 2 cycles then low; BusyCount goes 0,1,1,0.
REQ-039 IssueEn to reg 9 in the same cycle as a clearing write to reg 9 -> reg 9 stays pending, BusyCount = 1.
REQ-040 With regs 1-4 pending and data written, pulse Reset low between edges -> all outputs 0 immediately, with no edge needed.
